// File: rtl/life_seed_ctrl.sv
// Board-seeding sequencer: thresholds LFSR words into live/dead rows and writes one row per
// handshake into board memory after discarding a warmup run of LFSR words.
module life_seed_ctrl #(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned COLS   = 16,
    parameter int unsigned WARMUP = 8,
    localparam int unsigned RW    = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      density,
    input  logic [31:0]     rnd,
    input  logic            wr_ready,
    output logic            wr_en,
    output logic [RW-1:0]   wr_row,
    output logic [COLS-1:0] wr_data,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CntW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StWrite,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] data_q, data_d;
    logic [1:0]      dens_q, dens_d;

    // Bit c is the AND of 1, 2 or 3 consecutive rnd bits starting at c, wrapping at bit 31.
    function automatic logic [COLS-1:0] seed_row(input logic [1:0] dens, input logic [31:0] r);
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] m;
        r1 = {r[0], r[31:1]};
        r2 = {r[1:0], r[31:2]};
        case (dens)
            2'b00:   m = r;
            2'b01:   m = r & r1;
            2'b10:   m = r & r1 & r2;
            default: m = '0;
        endcase
        return m[COLS-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        data_d  = data_q;
        dens_d  = dens_q;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StWarmup;
                    dens_d  = density;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            StWarmup: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(WARMUP - 1)) begin
                    state_d = StWrite;
                    data_d  = seed_row(dens_q, rnd);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWrite: begin
                if (abort) begin
                    state_d = StIdle;
                    row_d   = '0;
                    data_d  = '0;
                end else if (wr_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = StDone;
                        row_d   = '0;
                        data_d  = '0;
                    end else begin
                        // Next row is sampled on the accepting edge so rows can stream 1/cycle.
                        row_d  = row_q + RW'(1);
                        data_d = seed_row(dens_q, rnd);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            row_q   <= '0;
            data_q  <= '0;
            dens_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            data_q  <= data_d;
            dens_q  <= dens_d;
        end
    end

    assign wr_en   = (state_q == StWrite);
    assign busy    = (state_q == StWarmup) || (state_q == StWrite);
    assign done    = (state_q == StDone);
    assign wr_row  = row_q;
    assign wr_data = data_q;

endmodule

// File: tb/tb_life_seed_ctrl.sv
// Scoreboard bench for life_seed_ctrl: expected rows are queued as LFSR words are driven and
// popped as the DUT presents accepted writes.
module tb_life_seed_ctrl;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 16;
    localparam int unsigned WARMUP = 8;
    localparam int unsigned RW     = 2;

    logic            clk      = 1'b0;
    logic            reset    = 1'b0;
    logic            start    = 1'b0;
    logic            abort    = 1'b0;
    logic [1:0]      density  = 2'b00;
    logic [31:0]     rnd      = '0;
    logic            wr_ready = 1'b0;
    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic            busy;
    logic            done;

    int n_vec = 0;
    int n_err = 0;
    logic [RW+COLS-1:0] exp_q[$];

    always #5 clk = ~clk;

    life_seed_ctrl #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .WARMUP (WARMUP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .density  (density),
        .rnd      (rnd),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [COLS-1:0] model_f(input logic [1:0] d, input logic [31:0] r);
        logic [COLS-1:0] v;
        for (int c = 0; c < int'(COLS); c++) begin
            case (d)
                2'b00:   v[c] = r[c];
                2'b01:   v[c] = r[c] & r[(c + 1) % 32];
                2'b10:   v[c] = r[c] & r[(c + 1) % 32] & r[(c + 2) % 32];
                default: v[c] = 1'b0;
            endcase
        end
        return v;
    endfunction

    // phase: 0 warmup, 1 write, 2 done cycle, 3 after abort
    task automatic run_pass(input logic [1:0] dens, input bit fixed, input logic [31:0] fixed_val,
                            input int stall_row, input int stall_len, input int abort_row,
                            input bit extra_starts, output int done_cyc);
        int phase = 0;
        int mrow = 0;
        int stalls_left = stall_len;
        bit fin = 0;
        logic [2:0] exp_ctl;
        logic [RW+COLS-1:0] head;
        exp_q.delete();
        done_cyc = -1;
        @(negedge clk);
        start    = 1'b1;
        abort    = 1'b0;
        density  = dens;
        wr_ready = 1'b1;
        rnd      = fixed ? fixed_val : $urandom;
        for (int cyc = 1; cyc < 80 && !fin; cyc++) begin
            @(negedge clk);
            start   = 1'b0;
            abort   = 1'b0;
            density = ~dens;
            rnd     = fixed ? fixed_val : $urandom;
            case (phase)
                0:       exp_ctl = 3'b010;
                1:       exp_ctl = 3'b110;
                2:       exp_ctl = 3'b001;
                default: exp_ctl = 3'b000;
            endcase
            n_vec++;
            if ({wr_en, busy, done} !== exp_ctl) begin
                n_err++;
                $display("FAIL ctl cyc=%0d dens=%b: {wr_en,busy,done} got %b want %b",
                         cyc, dens, {wr_en, busy, done}, exp_ctl);
            end
            if (phase == 1) begin
                head = (exp_q.size() > 0) ? exp_q[0] : 'x;
                n_vec++;
                if ({wr_row, wr_data} !== head) begin
                    n_err++;
                    $display("FAIL row cyc=%0d dens=%b: row/data got %0d/%h want %0d/%h",
                             cyc, dens, wr_row, wr_data, head[RW+COLS-1:COLS], head[COLS-1:0]);
                end
            end
            case (phase)
                0: begin
                    if (extra_starts && cyc == 3) start = 1'b1;
                    if (cyc == int'(WARMUP)) begin
                        exp_q.push_back({RW'(0), model_f(dens, rnd)});
                        phase = 1;
                    end
                end
                1: begin
                    if (mrow == abort_row) begin
                        abort    = 1'b1;
                        wr_ready = 1'b1;
                        void'(exp_q.pop_front());
                        phase = 3;
                    end else if (mrow == stall_row && stalls_left > 0) begin
                        wr_ready = 1'b0;
                        stalls_left--;
                    end else begin
                        wr_ready = 1'b1;
                        void'(exp_q.pop_front());
                        if (mrow == int'(ROWS) - 1) begin
                            phase = 2;
                        end else begin
                            mrow++;
                            exp_q.push_back({RW'(mrow), model_f(dens, rnd)});
                        end
                    end
                end
                2: begin
                    done_cyc = cyc;
                    if (extra_starts) start = 1'b1;
                    fin = 1;
                end
                default: fin = 1;
            endcase
        end
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL pass_timeout dens=%b: got no completion want completion", dens);
        end
    endtask

    task automatic check_idle(input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            rnd   = $urandom;
            n_vec++;
            if ({wr_en, busy, done} !== 3'b000) begin
                n_err++;
                $display("FAIL %s cyc=%0d: {wr_en,busy,done} got %b want 000",
                         tag, i, {wr_en, busy, done});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_vec++;
        if ({wr_en, wr_row, wr_data, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_state: outputs got %b want 0",
                     {wr_en, wr_row, wr_data, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        check_idle(2, "reset_idle");
    endtask

    task automatic test_timing();
        int dc;
        run_pass(2'b00, 0, '0, -1, 0, -1, 0, dc);
        n_vec++;
        if (dc !== int'(WARMUP) + 5) begin
            n_err++;
            $display("FAIL done_timing: done cycle got %0d want %0d", dc, WARMUP + 5);
        end
    endtask

    task automatic test_density();
        int dc;
        run_pass(2'b11, 0, '0, -1, 0, -1, 0, dc);
        run_pass(2'b00, 1, 32'hA5A5_F00F, -1, 0, -1, 0, dc);
        run_pass(2'b01, 1, 32'h0000_0007, -1, 0, -1, 0, dc);
        run_pass(2'b10, 1, 32'h0000_0007, -1, 0, -1, 0, dc);
        run_pass(2'b10, 1, 32'h8000_0001, -1, 0, -1, 0, dc);
        run_pass(2'b01, 0, '0, -1, 0, -1, 0, dc);
        run_pass(2'b10, 0, '0, -1, 0, -1, 0, dc);
    endtask

    task automatic test_stall();
        int dc;
        run_pass(2'b00, 0, '0, 2, 3, -1, 0, dc);
        n_vec++;
        if (dc !== int'(WARMUP) + 8) begin
            n_err++;
            $display("FAIL stall_timing: done cycle got %0d want %0d", dc, WARMUP + 8);
        end
    endtask

    task automatic test_abort();
        int dc;
        run_pass(2'b01, 0, '0, -1, 0, 1, 0, dc);
        check_idle(5, "abort_no_done");
        test_timing();
    endtask

    task automatic test_back_to_back();
        int dc;
        run_pass(2'b00, 0, '0, -1, 0, -1, 0, dc);
        run_pass(2'b10, 0, '0, 0, 2, -1, 0, dc);
    endtask

    task automatic test_requeue();
        int dc;
        run_pass(2'b00, 0, '0, -1, 0, -1, 1, dc);
        n_vec++;
        if (dc !== int'(WARMUP) + 5) begin
            n_err++;
            $display("FAIL requeue_timing: done cycle got %0d want %0d", dc, WARMUP + 5);
        end
        check_idle(12, "start_not_queued");
    endtask

    task automatic test_idle_guard();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        check_idle(12, "start_abort_idle");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start    = 1'b1;
        density  = 2'b00;
        wr_ready = 1'b1;
        rnd      = $urandom;
        repeat (WARMUP + 3) begin
            @(negedge clk);
            start = 1'b0;
            rnd   = $urandom;
        end
        n_vec++;
        if ({wr_en, wr_row} !== {1'b1, RW'(2)}) begin
            n_err++;
            $display("FAIL pre_reset_row: {wr_en,wr_row} got %b want %b",
                     {wr_en, wr_row}, {1'b1, RW'(2)});
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({wr_en, wr_row, wr_data, busy, done} !== '0) begin
            n_err++;
            $display("FAIL async_reset: outputs got %b want 0",
                     {wr_en, wr_row, wr_data, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        check_idle(3, "post_reset_idle");
        test_timing();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_density();
        test_stall();
        test_abort();
        test_back_to_back();
        test_requeue();
        test_idle_guard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
